gcd_operand_sequencer: RTL and testbench
========================================

Name: gcd_operand_sequencer

Overview:
- Upstream feeder for the GCD datapath/controlpath pair.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Serialises each pair onto the core's single data_in bus (A, then B) with a start pulse, waits for done, and returns the result on a valid/ready output stream.
- Pairs with a zero operand are resolved locally, because the subtractive core never terminates on zero; a watchdog flags a hung core.

Parameters:
WIDTH, 16, operand/result width
DEPTH, 4, input FIFO entries (power of 2)
TIMEOUT, 1023, max WAIT cycles before error

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept (= !full)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
core_start  output  1  one-cycle start pulse to GCD core
core_data  output  WIDTH  core data_in bus
core_done  input  1  core finished (level)
core_result  input  WIDTH  core GCD value
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_gcd  output  WIDTH  GCD result
out_err  output  1  result is a timeout error
busy  output  1  state != IDLE
level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): FIFO emptied, state IDLE, timeout counter 0. core_start=0, core_data=0, out_valid=0, out_gcd=0, out_err=0, busy=0, level=0. Reset mid-job abandons the job; the core is not notified.
- FIFO:
  - Push on in_valid&&in_ready.
  - When full, in_ready=0 with no same-cycle pass-through, even if a pop occurs.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESULT.
- IDLE:
  - If FIFO non-empty, pop the head into job_a/job_b.
  - If job_a==0 or job_b==0: out_gcd <= job_a|job_b (gcd(0,0)=0), out_err <= 0, go to RESULT.
  - Otherwise go to LOAD_A.
- LOAD_A: core_start=1, core_data=job_a; go to LOAD_B.
- LOAD_B: core_start=0, core_data=job_b; clear timeout counter; go to WAIT.
- WAIT:
  - core_data holds job_b.
  - core_done is sampled only in WAIT; the core guarantees done is low by the first WAIT cycle.
  - core_done=1: out_gcd <= core_result, out_err <= 0, go to RESULT.
  - Else counter increments. On the counter reaching TIMEOUT: out_gcd <= 0, out_err <= 1, go to RESULT.
  - core_done and timeout in the same cycle: core_done wins.
- RESULT:
  - out_valid=1; out_gcd/out_err held stable until out_ready.
  - On out_valid&&out_ready go to IDLE; out_valid drops the next cycle.
  - No back-to-back issue: a new pop occurs in IDLE at the earliest one cycle after the handshake.
- Latency, pair pushed at edge 0 into an empty FIFO with FSM IDLE:
  - Popped in cycle 1.
  - Bypass: out_valid in cycle 2.
  - Core path: core_start in cycle 2, B on the bus in cycle 3, WAIT from cycle 4, out_valid the cycle after core_done is seen.
- core_start is never high outside LOAD_A. The FIFO keeps accepting pushes during any state.

Test Plan:
- Push (143,78); behavioural core model asserts done with result 13 after 20 cycles -> core_start high one cycle with core_data=143, next cycle core_data=78, then out_valid=1, out_gcd=13, out_err=0.
- Push (0,25), then (0,0), then (40,0) -> results 25, 0, 40 in order; core_start never asserted; first out_valid exactly 2 cycles after the first push.
- out_ready=0, core model always finishes; push 6 pairs back-to-back -> first pair popped into a job, FIFO reaches level=4, in_ready=0 on the 6th push. Raise out_ready -> all 6 results emerge in push order, and level returns to 0.
- TIMEOUT=15, core_done tied 0, push (9,6) -> out_valid with out_err=1, out_gcd=0 exactly 15 WAIT cycles after entering WAIT; next pair proceeds normally.
- core_done rises on the same cycle the counter hits TIMEOUT -> out_err=0, out_gcd=core_result.
- In WAIT with 2 pairs queued, assert rst one cycle -> next cycle level=0, out_valid=0, core_start=0, busy=0. Fresh pair (21,14) after reset -> 7.

Source files
------------

// File: rtl/gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_operand_sequencer
//
// Upstream feeder for a subtractive GCD core. Operand pairs arrive on a
// valid/ready stream and are buffered in a small FIFO. Each pair is then
// serialised onto the core's single data bus (A with a start pulse, then B),
// the sequencer waits for done, and the result leaves on a valid/ready stream.
// Pairs containing a zero operand never reach the core, because the
// subtractive algorithm does not terminate on zero. A watchdog turns a hung
// core into an error result.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand pair stream (in_a, in_b); in_ready = FIFO not full
//   core_start      one-cycle start pulse, issued together with A on core_data
//   core_data       core data_in bus (A, then B, held during the wait)
//   core_done       core finished (level), sampled only while waiting
//   core_result     GCD value from the core
//   out_valid/ready result stream (out_gcd, out_err = timeout)
//   busy            sequencer is not idle
//   level           FIFO occupancy
// -----------------------------------------------------------------------------
module gcd_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_data,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_gcd,
  output logic                   out_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_RESULT
  } state_t;

  // FIFO storage (no reset needed: occupancy is tracked by count_q)
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  job_b_q, job_b_d;    // A goes out immediately; only B must wait a cycle
  logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              core_start_q, core_start_d;
  logic [WIDTH-1:0]  core_data_q, core_data_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_gcd_q, out_gcd_d;
  logic              out_err_q, out_err_d;
  logic              busy_q, busy_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;

  // A full FIFO refuses input even if a pop happens in the same cycle.
  assign full   = (count_q == LW'(DEPTH));
  assign empty  = (count_q == '0);
  assign push   = in_valid && !full;
  assign head_a = mem_a[rd_ptr_q];
  assign head_b = mem_b[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    job_b_d      = job_b_q;
    tmo_cnt_d    = tmo_cnt_q;
    core_start_d = 1'b0;
    core_data_d  = core_data_q;
    out_valid_d  = out_valid_q;
    out_gcd_d    = out_gcd_q;
    out_err_d    = out_err_q;
    pop          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          job_b_d = head_b;
          if (head_a == '0 || head_b == '0) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so OR gives the answer directly
            out_gcd_d   = head_a | head_b;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_RESULT;
          end else begin
            core_start_d = 1'b1;
            core_data_d  = head_a;
            state_d      = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        core_data_d = job_b_q;
        state_d     = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + CW'(1);
        if (core_done) begin
          // done takes priority over a watchdog expiring in the same cycle
          out_gcd_d   = core_result;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      job_b_q      <= '0;
      tmo_cnt_q    <= '0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      job_b_q      <= job_b_d;
      tmo_cnt_q    <= tmo_cnt_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      out_valid_q  <= out_valid_d;
      out_gcd_q    <= out_gcd_d;
      out_err_q    <= out_err_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  assign in_ready   = !full;
  assign level      = count_q;
  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_err    = out_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for gcd_operand_sequencer (WIDTH=16, DEPTH=4, TIMEOUT=15).
// Contains a behavioural GCD core, a job-level reference model (FIFO as a
// queue, job progress as an age count), a per-cycle compare process, directed
// scenarios with literal expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_gcd_operand_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
  logic [2:0]   level;

  gcd_operand_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_start (core_start),
    .core_data  (core_data),
    .core_done  (core_done),
    .core_result(core_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .busy       (busy),
    .level      (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural GCD core: sees A with start, B on the next cycle, then raises
  // done during wait cycle c_lat (0-based, >= 1). lat_mode: -1 never finishes,
  // >0 fixed wait index, 0 random index in 1..16 (15 and 16 cause a timeout).
  // ---------------------------------------------------------------------------
  int           lat_mode = 0;
  int           c_stage  = 0;
  int           c_wi     = 0;
  int           c_lat    = 0;
  logic [W-1:0] c_a      = '0;
  logic [W-1:0] c_b      = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (core_start === 1'b1) begin
        c_a       = core_data;
        c_stage   = 1;
        core_done = 1'b0;
      end else if (c_stage == 1) begin
        c_b     = core_data;
        c_stage = 2;
        c_wi    = 0;
        c_lat   = (lat_mode == 0) ? int'($urandom_range(1, 16)) : lat_mode;
      end else if (c_stage == 2) begin
        if (c_lat >= 1 && c_wi == c_lat) begin
          core_done   = 1'b1;
          core_result = gcd_ref(c_a, c_b);
          c_stage     = 3;
        end
        c_wi++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model. A job's age counts cycles since it was popped:
  // age 1 = start cycle (A on bus), 2 = B on bus, 3+ = waiting (index age-3).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t        m_q[$];
  pair_t        m_p;
  bit           m_job    = 0;
  int           m_age    = 0;
  logic [W-1:0] m_jb     = '0;
  bit           m_res    = 0;
  logic [W-1:0] m_gcd    = '0;
  bit           m_err    = 0;
  logic [W-1:0] m_cdata  = '0;
  bit           m_pushed = 0;
  bit           m_can_pop;
  bit           m_do_push;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_q.delete();
        m_job    = 0;
        m_age    = 0;
        m_res    = 0;
        m_gcd    = '0;
        m_err    = 0;
        m_cdata  = '0;
        m_pushed = 0;
      end else begin
        m_can_pop = !m_job && !m_res && (m_q.size() > 0);
        m_do_push = in_valid && (m_q.size() < DEPTH);
        if (m_res && out_ready) m_res = 0;
        if (m_job) begin
          if (m_age >= 3) begin
            if (core_done) begin
              m_job = 0; m_res = 1; m_gcd = core_result; m_err = 0;
            end else if ((m_age - 3) + 1 == TMO) begin
              m_job = 0; m_res = 1; m_gcd = '0; m_err = 1;
            end else begin
              m_age++;
            end
          end else begin
            m_age++;
            if (m_age == 2) m_cdata = m_jb;
          end
        end
        if (m_can_pop) begin
          m_p = m_q.pop_front();
          if (m_p.a == 0 || m_p.b == 0) begin
            m_res = 1; m_gcd = m_p.a | m_p.b; m_err = 0;
          end else begin
            m_job = 1; m_age = 1; m_jb = m_p.b; m_cdata = m_p.a;
          end
        end
        if (m_do_push) begin
          m_p.a = in_a;
          m_p.b = in_b;
          m_q.push_back(m_p);
        end
        m_pushed = m_do_push;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and result monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] g;
    logic         e;
    int           c;
  } res_t;

  res_t res_q[$];
  res_t r;
  bit   start_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
        check("level",      32'(level),      32'(m_q.size()));
        check("busy",       32'(busy),       32'(m_job || m_res));
        check("core_start", 32'(core_start), 32'(m_job && m_age == 1));
        check("core_data",  32'(core_data),  32'(m_cdata));
        check("out_valid",  32'(out_valid),  32'(m_res));
        if (m_res) begin
          check("out_gcd", 32'(out_gcd), 32'(m_gcd));
          check("out_err", 32'(out_err), 32'(m_err));
        end
        if (core_start === 1'b1) start_seen = 1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          r.g = out_gcd;
          r.e = out_err;
          r.c = cyc;
          res_q.push_back(r);
          $display("[TB] result gcd=%0d err=%0d cycle=%0d", out_gcd, out_err, cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    c_stage   = 0;
    core_done = 1'b0;
  endtask

  // Presents a pair until accepted; pc = index of the accepting cycle.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int pc);
    int c;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    pc       = -1;
    for (int t = 0; t < 300; t++) begin
      c = cyc;
      step();
      if (m_pushed) begin
        pc = c;
        break;
      end
    end
    in_valid = 1'b0;
    if (pc < 0) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL push_accept: got no acceptance, expected acceptance of (%0d,%0d)", a, b);
    end
  endtask

  task automatic wait_start(output int s);
    s = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        s = cyc;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("[TB] FAIL wait_start: got no core_start, expected one within 100 cycles");
  endtask

  task automatic wait_valid(output int q);
    q = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        q = cyc;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("[TB] FAIL wait_valid: got no out_valid, expected one within 200 cycles");
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 600; t++) begin
      if (res_q.size() >= n) return;
      @(negedge clk);
    end
    n_tests++; n_fail++;
    $display("[TB] FAIL wait_results: got %0d results, expected %0d", res_q.size(), n);
  endtask

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 20) * $urandom_range(1, 12));
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pc, s, q, x;
    logic [W-1:0] exp_g [6];

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    step();
    chk_en = 1;
    reset_dut();

    // Reset state
    @(negedge clk);
    check("rst_level",      32'(level),      0);
    check("rst_in_ready",   32'(in_ready),   1);
    check("rst_busy",       32'(busy),       0);
    check("rst_out_valid",  32'(out_valid),  0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_data",  32'(core_data),  0);
    check("rst_out_gcd",    32'(out_gcd),    0);
    check("rst_out_err",    32'(out_err),    0);
    step();

    // Core path: (143,78) -> 13
    lat_mode  = 10;
    out_ready = 1'b1;
    push(16'd143, 16'd78, pc);
    wait_start(s);
    check("t1_start_cycle", 32'(s - pc), 2);
    check("t1_data_a",      32'(core_data), 143);
    @(negedge clk);
    check("t1_start_drop",  32'(core_start), 0);
    check("t1_data_b",      32'(core_data), 78);
    wait_valid(q);
    check("t1_gcd",         32'(out_gcd), 13);
    check("t1_err",         32'(out_err), 0);
    check("t1_latency",     32'(q - s), 2 + 10 + 1);
    step();
    step();

    // Zero-operand bypass: (0,25), (0,0), (40,0) -> 25, 0, 40
    reset_dut();
    res_q.delete();
    start_seen = 0;
    push(16'd0, 16'd25, pc);
    push(16'd0, 16'd0, x);
    push(16'd40, 16'd0, x);
    wait_results(3);
    if (res_q.size() >= 3) begin
      check("t2_first_latency", 32'(res_q[0].c - pc), 2);
      check("t2_res0", 32'(res_q[0].g), 25);
      check("t2_res1", 32'(res_q[1].g), 0);
      check("t2_res2", 32'(res_q[2].g), 40);
      check("t2_err",  32'(res_q[0].e | res_q[1].e | res_q[2].e), 0);
    end
    check("t2_no_start", 32'(start_seen), 0);
    step();

    // Backpressure: six pairs with out_ready low
    reset_dut();
    res_q.delete();
    out_ready = 1'b0;
    lat_mode  = 3;
    exp_g = '{16'd4, 16'd9, 16'd25, 16'd1, 16'd12, 16'd27};
    push(16'd12, 16'd8, x);
    push(16'd0, 16'd9, x);
    push(16'd100, 16'd75, x);
    push(16'd7, 16'd13, x);
    push(16'd48, 16'd36, x);
    in_valid = 1'b1;
    in_a     = 16'd81;
    in_b     = 16'd27;
    repeat (3) step();
    @(negedge clk);
    check("t3_level_full", 32'(level),    4);
    check("t3_in_ready",   32'(in_ready), 0);
    step();
    out_ready = 1'b1;
    x = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      if (m_pushed) begin
        x = 1;
        break;
      end
    end
    in_valid = 1'b0;
    check("t3_sixth_accepted", 32'(x), 1);
    wait_results(6);
    for (int i = 0; i < 6; i++) begin
      if (i < res_q.size()) check($sformatf("t3_res%0d", i), 32'(res_q[i].g), 32'(exp_g[i]));
    end
    repeat (3) step();
    @(negedge clk);
    check("t3_level_empty", 32'(level), 0);
    check("t3_busy_idle",   32'(busy),  0);
    step();

    // Watchdog: core never finishes
    reset_dut();
    res_q.delete();
    lat_mode = -1;
    push(16'd9, 16'd6, pc);
    wait_start(s);
    wait_valid(q);
    check("t4_tmo_latency", 32'(q - s), 2 + TMO);
    check("t4_tmo_err",     32'(out_err), 1);
    check("t4_tmo_gcd",     32'(out_gcd), 0);
    step();
    lat_mode = 4;
    push(16'd12, 16'd18, pc);
    wait_results(2);
    if (res_q.size() >= 2) begin
      check("t4_next_gcd", 32'(res_q[1].g), 6);
      check("t4_next_err", 32'(res_q[1].e), 0);
    end
    step();

    // done arrives in the same cycle the watchdog would expire
    reset_dut();
    lat_mode = TMO - 1;
    push(16'd35, 16'd21, pc);
    wait_start(s);
    wait_valid(q);
    check("t5_latency", 32'(q - s), 2 + TMO);
    check("t5_err",     32'(out_err), 0);
    check("t5_gcd",     32'(out_gcd), 7);
    step();

    // Reset while waiting with two pairs queued
    reset_dut();
    res_q.delete();
    lat_mode = -1;
    push(16'd30, 16'd12, x);
    push(16'd5, 16'd10, x);
    push(16'd8, 16'd4, x);
    repeat (4) @(negedge clk);
    check("t6_pre_level", 32'(level), 2);
    check("t6_pre_busy",  32'(busy),  1);
    step();
    reset_dut();
    @(negedge clk);
    check("t6_level",      32'(level),      0);
    check("t6_out_valid",  32'(out_valid),  0);
    check("t6_core_start", 32'(core_start), 0);
    check("t6_busy",       32'(busy),       0);
    step();
    lat_mode = 3;
    res_q.delete();
    push(16'd21, 16'd14, x);
    wait_results(1);
    if (res_q.size() >= 1) check("t6_fresh_gcd", 32'(res_q[0].g), 7);
    step();

    // Randomized traffic checked cycle by cycle against the model
    lat_mode = 0;
    reset_dut();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = rnd_op();
      in_b      = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) reset_dut();
      else step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (150) step();
    @(negedge clk);
    check("rand_drained_level", 32'(level), 0);
    check("rand_drained_busy",  32'(busy),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
